// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: stallable registered fetch port, run-time program-load
// port, range/alignment fault detection, and a post-reset clear sequencer.
module instr_mem_sync #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 100,
  parameter int                BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              addr_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              ld_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0]  f_idx_full, l_idx_full;
  logic [IDX_W-1:0]   f_idx, l_idx;
  logic               f_fault, l_fault;
  logic               ld_write;
  logic [DATA_W-1:0]  fetch_word;

  function automatic logic [ADDR_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return (BYTE_ADDR != 0) ? (a >> 2) : a;
  endfunction

  function automatic logic is_fault(input logic [ADDR_W-1:0] a);
    return (to_idx(a) >= ADDR_W'(DEPTH)) || ((BYTE_ADDR != 0) && (a[1:0] != 2'b00));
  endfunction

  always_comb begin
    f_idx_full = to_idx(address);
    l_idx_full = to_idx(ld_addr);
    f_idx      = f_idx_full[IDX_W-1:0];
    l_idx      = l_idx_full[IDX_W-1:0];
    f_fault    = is_fault(address);
    l_fault    = is_fault(ld_addr);
    ld_write   = (state == READY) && ld_en && !l_fault;
    // Write-first: a load to the word being fetched this cycle is forwarded.
    fetch_word = (ld_write && (l_idx == f_idx)) ? ld_data : mem[f_idx];
  end

  // NOTE: the array has no reset; the clear sequencer initialises it so it can map to RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_ptr] <= NOP_WORD;
      else if (ld_write)
        mem[l_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      busy        <= 1'b1;
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
      ld_ack      <= 1'b0;
      ld_err      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ld_ack <= 1'b0;
          ld_err <= 1'b0;
          if (clr_ptr == IDX_W'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        READY: begin
          ld_ack <= ld_en && !l_fault;
          ld_err <= ld_en && l_fault;
          if (!stall) begin
            if (fetch_en) begin
              instruction <= f_fault ? NOP_WORD : fetch_word;
              instr_valid <= 1'b1;
              addr_fault  <= f_fault;
            end else begin
              instr_valid <= 1'b0;
              addr_fault  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: word-indexed instance (DEPTH=8) plus a
// byte-addressed instance for the alignment rules.
module tb_instr_mem_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0, stall = 1'b0, ld_en = 1'b0;
  logic [31:0] address = '0, ld_addr = '0, ld_data = '0;
  logic [31:0] instruction;
  logic        instr_valid, addr_fault, ld_ack, ld_err, busy;

  logic        b_fetch_en = 1'b0, b_ld_en = 1'b0;
  logic [31:0] b_address = '0, b_ld_addr = '0, b_ld_data = '0;
  logic [31:0] b_instruction;
  logic        b_instr_valid, b_addr_fault, b_ld_ack, b_ld_err, b_busy;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  instr_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .BYTE_ADDR(0), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .address(address),
    .instruction(instruction), .instr_valid(instr_valid), .addr_fault(addr_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .ld_err(ld_err), .busy(busy)
  );

  instr_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .BYTE_ADDR(1), .NOP_WORD(32'h0)) dut_b (
    .clk(clk), .rst(rst), .fetch_en(b_fetch_en), .stall(1'b0), .address(b_address),
    .instruction(b_instruction), .instr_valid(b_instr_valid), .addr_fault(b_addr_fault),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_ack(b_ld_ack),
    .ld_err(b_ld_err), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL reset_busy: got %b want 1", busy); end
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests++; if (instruction !== 32'h0) begin failed++; $display("FAIL reset_instr: got %h want 0", instruction); end
    tests++; if (addr_fault !== 1'b0) begin failed++; $display("FAIL reset_fault: got %b want 0", addr_fault); end
    tests++; if ({ld_ack, ld_err} !== 2'b00) begin failed++; $display("FAIL reset_ld: got %b want 00", {ld_ack, ld_err}); end
    // Requests during CLEAR must be ignored.
    fetch_en = 1'b1; address = 32'd2;
    ld_en = 1'b1; ld_addr = 32'd2; ld_data = 32'hA800_0003;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
      tests++;
      if ({instr_valid, ld_ack, ld_err} !== 3'b000) begin
        failed++; $display("FAIL clear_ignore: cycle %0d got v/ack/err %b want 000", cnt, {instr_valid, ld_ack, ld_err});
      end
    end
    fetch_en = 1'b0; ld_en = 1'b0;
    tests++; if (cnt !== 8) begin failed++; $display("FAIL clear_len: got %0d busy cycles want 8", cnt); end
    tests++; if (b_busy !== 1'b0) begin failed++; $display("FAIL clear_len_b: got busy %b want 0", b_busy); end
  endtask

  task automatic test_clear_fill();
    for (int i = 0; i < 8; i++) begin
      fetch_en = 1'b1; address = i;
      tick();
      tests++;
      if ({instruction, instr_valid, addr_fault} !== {32'h0, 1'b1, 1'b0}) begin
        failed++; $display("FAIL clear_fill[%0d]: got %h v%b f%b want 0 v1 f0", i, instruction, instr_valid, addr_fault);
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_load_fetch();
    ld_en = 1'b1; ld_addr = 32'd3; ld_data = 32'h0465_0010;
    tick();
    ld_en = 1'b0;
    tests++; if ({ld_ack, ld_err} !== 2'b10) begin failed++; $display("FAIL load_ack: got ack/err %b want 10", {ld_ack, ld_err}); end
    fetch_en = 1'b1; address = 32'd3;
    tick();
    tests++; if (ld_ack !== 1'b0) begin failed++; $display("FAIL load_ack_pulse: got %b want 0", ld_ack); end
    tests++; if (instruction !== 32'h0465_0010 || instr_valid !== 1'b1) begin
      failed++; $display("FAIL load_fetch: got %h v%b want 04650010 v1", instruction, instr_valid); end
    // Same-cycle load and fetch of idx 4: write-first.
    ld_en = 1'b1; ld_addr = 32'd4; ld_data = 32'hA800_FFFD; address = 32'd4;
    tick();
    ld_en = 1'b0;
    tests++; if (instruction !== 32'hA800_FFFD) begin failed++; $display("FAIL collision: got %h want a800fffd", instruction); end
    tests++; if (ld_ack !== 1'b1) begin failed++; $display("FAIL collision_ack: got %b want 1", ld_ack); end
    tick();
    tests++; if (instruction !== 32'hA800_FFFD) begin failed++; $display("FAIL collision_kept: got %h want a800fffd", instruction); end
    fetch_en = 1'b0;
  endtask

  task automatic test_faults();
    fetch_en = 1'b1; address = 32'd8;
    tick();
    tests++; if ({instruction, instr_valid, addr_fault} !== {32'h0, 1'b1, 1'b1}) begin
      failed++; $display("FAIL fetch_range: got %h v%b f%b want 0 v1 f1", instruction, instr_valid, addr_fault); end
    address = 32'd3;
    tick();
    tests++; if (instruction !== 32'h0465_0010 || addr_fault !== 1'b0) begin
      failed++; $display("FAIL fetch_after_fault: got %h f%b want 04650010 f0", instruction, addr_fault); end
    fetch_en = 1'b0;
    ld_en = 1'b1; ld_addr = 32'd9; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0;
    tests++; if ({ld_ack, ld_err} !== 2'b01) begin failed++; $display("FAIL load_range: got ack/err %b want 01", {ld_ack, ld_err}); end
    tests++; if ({instr_valid, addr_fault} !== 2'b00 || instruction !== 32'h0465_0010) begin
      failed++; $display("FAIL idle_hold: got %h v%b f%b want 04650010 v0 f0", instruction, instr_valid, addr_fault); end
    tick();
    tests++; if (ld_err !== 1'b0) begin failed++; $display("FAIL load_err_pulse: got %b want 0", ld_err); end
    // Byte-addressed instance.
    b_fetch_en = 1'b1; b_address = 32'h6;
    tick();
    tests++; if ({b_instruction, b_instr_valid, b_addr_fault} !== {32'h0, 1'b1, 1'b1}) begin
      failed++; $display("FAIL byte_misalign: got %h v%b f%b want 0 v1 f1", b_instruction, b_instr_valid, b_addr_fault); end
    b_fetch_en = 1'b0;
    b_ld_en = 1'b1; b_ld_addr = 32'hC; b_ld_data = 32'h1234_5678;
    tick();
    b_ld_en = 1'b0;
    tests++; if (b_ld_ack !== 1'b1) begin failed++; $display("FAIL byte_load: got ack %b want 1", b_ld_ack); end
    b_fetch_en = 1'b1; b_address = 32'hC;
    tick();
    tests++; if (b_instruction !== 32'h1234_5678 || b_addr_fault !== 1'b0) begin
      failed++; $display("FAIL byte_idx3: got %h f%b want 12345678 f0", b_instruction, b_addr_fault); end
    b_address = 32'h20;
    tick();
    tests++; if (b_addr_fault !== 1'b1 || b_instruction !== 32'h0) begin
      failed++; $display("FAIL byte_range: got %h f%b want 0 f1", b_instruction, b_addr_fault); end
    b_fetch_en = 1'b0;
    b_ld_en = 1'b1; b_ld_addr = 32'h5;
    tick();
    b_ld_en = 1'b0;
    tests++; if ({b_ld_ack, b_ld_err} !== 2'b01) begin failed++; $display("FAIL byte_load_misalign: got %b want 01", {b_ld_ack, b_ld_err}); end
  endtask

  task automatic test_stall();
    fetch_en = 1'b1; address = 32'd3;
    tick();
    stall = 1'b1; address = 32'd4;
    ld_en = 1'b1; ld_addr = 32'd5; ld_data = 32'h1111_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        ld_en = 1'b0;
        tests++; if (ld_ack !== 1'b1) begin failed++; $display("FAIL stall_load: got ack %b want 1", ld_ack); end
      end
      tests++;
      if (instruction !== 32'h0465_0010 || instr_valid !== 1'b1) begin
        failed++; $display("FAIL stall_hold[%0d]: got %h v%b want 04650010 v1", i, instruction, instr_valid);
      end
    end
    stall = 1'b0;
    tick();
    tests++; if (instruction !== 32'hA800_FFFD || instr_valid !== 1'b1) begin
      failed++; $display("FAIL stall_release: got %h v%b want a800fffd v1", instruction, instr_valid); end
    fetch_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    int          idx [4];
    exp = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'h1111_5555};
    idx = '{0, 1, 2, 5};
    for (int i = 0; i < 3; i++) begin
      ld_en = 1'b1; ld_addr = i; ld_data = 32'hB000_0000 + i;
      tick();
      tests++; if (ld_ack !== 1'b1) begin failed++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, ld_ack); end
    end
    ld_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_en = 1'b1; address = idx[i];
      tick();
      tests++;
      if (instruction !== exp[i] || instr_valid !== 1'b1) begin
        failed++; $display("FAIL b2b_fetch[%0d]: got %h v%b want %h v1", idx[i], instruction, instr_valid, exp[i]);
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL mid_clear_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    tests++; if (cnt !== 8) begin failed++; $display("FAIL mid_clear_len: got %0d busy cycles want 8", cnt); end
    for (int i = 0; i < 8; i++) begin
      fetch_en = 1'b1; address = i;
      tick();
      tests++;
      if (instruction !== 32'h0 || instr_valid !== 1'b1) begin
        failed++; $display("FAIL mid_clear_fill[%0d]: got %h v%b want 0 v1", i, instruction, instr_valid);
      end
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    test_reset();
    test_clear_fill();
    test_load_fetch();
    test_faults();
    test_stall();
    test_back_to_back();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
